memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- Memory stage of the 5-stage RV32 pipeline; consumes the Execute→Memory register outputs (ALUResultM, WriteDataM, RDM, RegWriteM, MemWriteM, ResultSrcM, PCPlus4M).
- Holds a word-organised data memory with byte-lane stores and sign/zero-extended loads.
- Registers results into the Memory→Writeback pipeline register and drives the writeback result mux.
- ResultW feeds back to Execute forwarding; RDW/RegWriteW feed the hazard unit.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit data memory words (power of 2)
ADDR_W, 10, word index width = log2(DEPTH_WORDS)
INIT_FILE, "", optional $readmemh image loaded at time 0; empty means no preload

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
RegWriteM  in  3  load/writeback type: 000 none, 001 word/ALU, 010 LB, 011 LH, 100 LBU, 101 LHU, 110/111 treated as 001
ResultSrcM  in  2  00 ALU, 01 memory, 10 PC+4, 11 treated as 00
MemWriteM  in  2  00 none, 01 SB, 10 SH, 11 SW
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data (forwarded rs2)
PCPlus4M  in  32  return address for JAL/JALR
RDM  in  5  destination register
RegWriteW  out  3  registered RegWriteM
RDW  out  5  registered RDM
ResultW  out  32  writeback value selected by registered ResultSrc
MisalignedW  out  1  registered flag: access in M was misaligned

Behaviour:
- Word index = ALUResultM[ADDR_W+1:2]; upper address bits ignored (aliasing/wrap-around, no fault).
- Memory is not reset. Contents are undefined unless INIT_FILE is given.
- Store: written on the rising clk edge while rst=1, with per-byte lane enables.
  - SB: lane = addr[1:0], byte = WriteDataM[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}, data = WriteDataM[15:0].
  - SW: all lanes.
- Misaligned: SH with addr[0]=1, SW with addr[1:0]≠0, LH/LHU with addr[0]=1, or word load (RegWriteM=001 and ResultSrcM=01) with addr[1:0]≠0.
  - A misaligned store writes nothing.
  - A misaligned load returns 0 and still writes back.
  - MisalignedW=1 for exactly the following cycle.
- Read: combinational in M from the current memory array.
  - Store in cycle N followed by a load of the same word in cycle N+1 returns the new data; no bypass needed.
  - Store and load cannot coincide in one instruction.
- Load extraction by RegWriteM:
  - LB: sign-extend the selected byte; LBU: zero-extend it.
  - LH: sign-extend the selected half; LHU: zero-extend it.
  - Other values: full word.
- M→W register: on each rising clk, captures RegWriteM, RDM, the ResultSrc (11 normalised to 00), ALUResultM, extracted load data, PCPlus4M and the misaligned flag. No stall or flush inputs.
- ResultW = mux(ResultSrcW: ALUResultW, ReadDataW, PCPlus4W).
- Latency: M inputs appear on W outputs 1 cycle later. Store visible to loads 1 cycle later.
- Reset:
  - rst=0 asynchronously clears all W registers to 0.
  - All outputs are forced to 0 combinationally while rst=0.
  - Stores are blocked during reset.
  - Reset mid-stream discards the in-flight M instruction. After release, the first edge captures the current M inputs.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, next cycle LW 0x10 → one cycle later ResultW=0xDEADBEEF, RegWriteW=001, MisalignedW=0.
- After the above: SB 0x7F to addr 0x11, then LB 0x11 → 0x0000007F; LBU 0x13 → 0x000000DE; LB 0x13 → 0xFFFFFFDE.
- SH 0x8001 to addr 0x12, then LH 0x12 → 0xFFFF8001, LHU 0x12 → 0x00008001, LW 0x10 → 0x80017FEF.
- SW to addr 0x22 → MisalignedW=1 next cycle, word at 0x20 unchanged; LH addr 0x13 → ResultW=0, MisalignedW=1.
- ResultSrcM=10, PCPlus4M=0x104, RDM=1 → ResultW=0x104, RDW=1. ResultSrcM=11, ALUResultM=0x55 → ResultW=0x55.
- Assert rst=0 mid-stream with SW pending in M → outputs 0 immediately, target word unchanged. Release → normal capture on the next edge. Address 0x1010 with DEPTH_WORDS=1024 aliases word 4 (0x10).

Source files
------------

// File: rtl/memory_cycle_if.sv
// Memory-stage bus: Execute->Memory register outputs in, Memory->Writeback outputs out.
//   master : pipeline side (drives M-stage fields, observes W-stage fields)
//   slave  : memory_cycle (consumes M-stage fields, drives W-stage fields)
interface memory_cycle_if;
    // M-stage inputs
    logic [2:0]  RegWriteM;   // 000 none, 001 word/ALU, 010 LB, 011 LH, 100 LBU, 101 LHU
    logic [1:0]  ResultSrcM;  // 00 ALU, 01 memory, 10 PC+4
    logic [1:0]  MemWriteM;   // 00 none, 01 SB, 10 SH, 11 SW
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RDM;
    // W-stage outputs
    logic [2:0]  RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        MisalignedW;

    modport master (
        output RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RDM,
        input  RegWriteW, RDW, ResultW, MisalignedW
    );

    modport slave (
        input  RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, PCPlus4M, RDM,
        output RegWriteW, RDW, ResultW, MisalignedW
    );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage of the RV32 pipeline: word-organised data memory with byte-lane stores,
// sign/zero-extending loads, the M->W pipeline register and the writeback result mux.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset; clears W registers, forces outputs to 0, blocks stores
//   bus  - memory_cycle_if.slave: M-stage inputs, W-stage outputs (RegWriteW, RDW, ResultW,
//          MisalignedW)
module memory_cycle #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter string       INIT_FILE   = ""
) (
    input logic           clk,
    input logic           rst,
    memory_cycle_if.slave bus
);

    localparam logic [2:0] RwLb   = 3'b010;
    localparam logic [2:0] RwLh   = 3'b011;
    localparam logic [2:0] RwLbu  = 3'b100;
    localparam logic [2:0] RwLhu  = 3'b101;
    localparam logic [1:0] SrcAlu = 2'b00;
    localparam logic [1:0] SrcMem = 2'b01;
    localparam logic [1:0] SrcPc4 = 2'b10;
    localparam logic [1:0] MwSb   = 2'b01;
    localparam logic [1:0] MwSh   = 2'b10;
    localparam logic [1:0] MwSw   = 2'b11;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              word_ld;
    logic              st_mis;
    logic              ld_mis;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [15:0]       rd_half;
    logic [31:0]       ld_data;

    // Upper address bits are ignored, so accesses alias modulo the memory size.
    assign word_idx = bus.ALUResultM[ADDR_W+1:2];
    assign byte_off = bus.ALUResultM[1:0];

    always_comb begin
        word_ld = (bus.RegWriteM == 3'b001 || bus.RegWriteM == 3'b110 ||
                   bus.RegWriteM == 3'b111) && (bus.ResultSrcM == SrcMem);

        case (bus.MemWriteM)
            MwSh:    st_mis = byte_off[0];
            MwSw:    st_mis = (byte_off != 2'b00);
            default: st_mis = 1'b0;
        endcase

        ld_mis = ((bus.RegWriteM == RwLh || bus.RegWriteM == RwLhu) && byte_off[0]) ||
                 (word_ld && byte_off != 2'b00);

        // Store data is replicated across lanes so the lane enables alone pick the target bytes.
        case (bus.MemWriteM)
            MwSb: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{bus.WriteDataM[7:0]}};
            end
            MwSh: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.WriteDataM[15:0]}};
            end
            MwSw: begin
                be    = 4'b1111;
                wdata = bus.WriteDataM;
            end
            default: begin
                be    = 4'b0000;
                wdata = bus.WriteDataM;
            end
        endcase
        if (st_mis || !rst) be = 4'b0000;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Combinational read: a store on the previous edge is already in the array.
    always_comb begin
        rd_word  = mem_q[word_idx];
        rd_shift = rd_word >> {byte_off, 3'b000};
        rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.RegWriteM)
            RwLb:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            RwLbu:   ld_data = {24'h0, rd_shift[7:0]};
            RwLh:    ld_data = {{16{rd_half[15]}}, rd_half};
            RwLhu:   ld_data = {16'h0, rd_half};
            default: ld_data = rd_word;
        endcase
        if (ld_mis) ld_data = 32'h0;
    end

    logic [2:0]  regwrite_q;
    logic [4:0]  rd_q;
    logic [1:0]  src_q;
    logic [31:0] alu_q;
    logic [31:0] rdata_q;
    logic [31:0] pc4_q;
    logic        mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 3'b000;
            rd_q       <= 5'd0;
            src_q      <= SrcAlu;
            alu_q      <= 32'h0;
            rdata_q    <= 32'h0;
            pc4_q      <= 32'h0;
            mis_q      <= 1'b0;
        end else begin
            regwrite_q <= bus.RegWriteM;
            rd_q       <= bus.RDM;
            src_q      <= (bus.ResultSrcM == 2'b11) ? SrcAlu : bus.ResultSrcM;
            alu_q      <= bus.ALUResultM;
            rdata_q    <= ld_data;
            pc4_q      <= bus.PCPlus4M;
            mis_q      <= st_mis | ld_mis;
        end
    end

    logic [31:0] result;

    always_comb begin
        case (src_q)
            SrcMem:  result = rdata_q;
            SrcPc4:  result = pc4_q;
            default: result = alu_q;
        endcase
        // Outputs are held at 0 for the whole reset window, not just after the clearing edge.
        bus.ResultW     = rst ? result     : 32'h0;
        bus.RegWriteW   = rst ? regwrite_q : 3'b000;
        bus.RDW         = rst ? rd_q       : 5'd0;
        bus.MisalignedW = rst & mis_q;
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: a byte-addressed reference model predicts W-stage outputs,
// a negedge process compares them every cycle, and literal checks pin key results.
module tb_memory_cycle;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Bytes = 4 * Depth;

    logic clk;
    logic rst;

    memory_cycle_if bus ();

    memory_cycle #(
        .DEPTH_WORDS(Depth),
        .ADDR_W     (10),
        .INIT_FILE  ("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic        cmp_en;
    logic [2:0]  exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic        exp_mis;

    logic [7:0] mbytes [Bytes];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("RegWriteW", 32'(bus.RegWriteW), 32'(exp_rw));
            chk("RDW", 32'(bus.RDW), 32'(exp_rd));
            chk("ResultW", bus.ResultW, exp_res);
            chk("MisalignedW", 32'(bus.MisalignedW), 32'(exp_mis));
        end
    end

    // Drive one M-stage instruction, clock it, update the model and publish expected W outputs.
    task automatic issue(input logic [2:0] rw, input logic [1:0] src, input logic [1:0] mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd);
        int unsigned a;
        int unsigned st_n;
        int unsigned ld_n;
        int unsigned n;
        logic        ld_bad;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] res;
        bus.RegWriteM  = rw;
        bus.ResultSrcM = src;
        bus.MemWriteM  = mw;
        bus.ALUResultM = alu;
        bus.WriteDataM = wd;
        bus.PCPlus4M   = pc4;
        bus.RDM        = rd;

        a    = alu % Bytes;
        st_n = (mw == 2'd1) ? 1 : (mw == 2'd2) ? 2 : (mw == 2'd3) ? 4 : 0;
        case (rw)
            3'd2, 3'd4:       ld_n = 1;
            3'd3, 3'd5:       ld_n = 2;
            3'd1, 3'd6, 3'd7: ld_n = (src == 2'd1) ? 4 : 0;
            default:          ld_n = 0;
        endcase
        ld_bad = (ld_n > 1) && (a % ld_n != 0);
        mis    = ((st_n > 1) && (a % st_n != 0)) || ld_bad;

        rdata = 32'h0;
        if (src == 2'd1 && !ld_bad) begin
            n = (rw == 3'd2 || rw == 3'd4) ? 1 : (rw == 3'd3 || rw == 3'd5) ? 2 : 4;
            for (int i = 0; i < int'(n); i++) begin
                rdata = rdata | (32'(mbytes[(a + i) % Bytes]) << (8 * i));
            end
            if (rw == 3'd2 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
            if (rw == 3'd3 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
        end
        res = (src == 2'd2) ? pc4 : (src == 2'd1) ? rdata : alu;

        @(posedge clk);
        if (!mis && st_n != 0) begin
            for (int i = 0; i < int'(st_n); i++) begin
                mbytes[(a + i) % Bytes] = 8'(wd >> (8 * i));
            end
        end
        #1;
        exp_rw  = rw;
        exp_rd  = rd;
        exp_res = res;
        exp_mis = mis;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cmp_en  = 1'b1;
        exp_rw  = 3'd0;
        exp_rd  = 5'd0;
        exp_res = 32'h0;
        exp_mis = 1'b0;
        rst     = 1'b0;
        bus.RegWriteM  = 3'd1;
        bus.ResultSrcM = 2'd0;
        bus.MemWriteM  = 2'd0;
        bus.ALUResultM = 32'h55;
        bus.WriteDataM = 32'h0;
        bus.PCPlus4M   = 32'h4;
        bus.RDM        = 5'd7;

        #3;
        chk("reset_ResultW", bus.ResultW, 32'h0);
        chk("reset_RegWriteW", 32'(bus.RegWriteW), 32'h0);
        chk("reset_RDW", 32'(bus.RDW), 32'h0);
        chk("reset_MisalignedW", 32'(bus.MisalignedW), 32'h0);
        #9 rst = 1'b1;

        // Word store then load.
        issue(3'd0, 2'd0, 2'd3, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd0);
        issue(3'd1, 2'd1, 2'd0, 32'h10, 32'h0, 32'h0, 5'd5);
        chk("lw_10", bus.ResultW, 32'hDEAD_BEEF);
        chk("lw_10_rw", 32'(bus.RegWriteW), 32'h1);
        chk("lw_10_mis", 32'(bus.MisalignedW), 32'h0);

        // Byte store and byte loads.
        issue(3'd0, 2'd0, 2'd1, 32'h11, 32'h1234_567F, 32'h0, 5'd0);
        issue(3'd2, 2'd1, 2'd0, 32'h11, 32'h0, 32'h0, 5'd6);
        chk("lb_11", bus.ResultW, 32'h0000_007F);
        issue(3'd4, 2'd1, 2'd0, 32'h13, 32'h0, 32'h0, 5'd6);
        chk("lbu_13", bus.ResultW, 32'h0000_00DE);
        issue(3'd2, 2'd1, 2'd0, 32'h13, 32'h0, 32'h0, 5'd6);
        chk("lb_13", bus.ResultW, 32'hFFFF_FFDE);

        // Half store and half loads.
        issue(3'd0, 2'd0, 2'd2, 32'h12, 32'hABCD_8001, 32'h0, 5'd0);
        issue(3'd3, 2'd1, 2'd0, 32'h12, 32'h0, 32'h0, 5'd7);
        chk("lh_12", bus.ResultW, 32'hFFFF_8001);
        issue(3'd5, 2'd1, 2'd0, 32'h12, 32'h0, 32'h0, 5'd7);
        chk("lhu_12", bus.ResultW, 32'h0000_8001);
        issue(3'd1, 2'd1, 2'd0, 32'h10, 32'h0, 32'h0, 5'd7);
        chk("lw_10_merged", bus.ResultW, 32'h8001_7FEF);

        // Misaligned store writes nothing; misaligned loads return 0.
        issue(3'd0, 2'd0, 2'd3, 32'h20, 32'hCAFE_F00D, 32'h0, 5'd0);
        issue(3'd0, 2'd0, 2'd3, 32'h22, 32'h1111_1111, 32'h0, 5'd0);
        chk("sw_22_mis", 32'(bus.MisalignedW), 32'h1);
        issue(3'd1, 2'd1, 2'd0, 32'h20, 32'h0, 32'h0, 5'd8);
        chk("lw_20_unchanged", bus.ResultW, 32'hCAFE_F00D);
        chk("lw_20_mis", 32'(bus.MisalignedW), 32'h0);
        issue(3'd3, 2'd1, 2'd0, 32'h13, 32'h0, 32'h0, 5'd8);
        chk("lh_13_zero", bus.ResultW, 32'h0);
        chk("lh_13_mis", 32'(bus.MisalignedW), 32'h1);
        chk("lh_13_rw", 32'(bus.RegWriteW), 32'h3);
        issue(3'd0, 2'd0, 2'd2, 32'h21, 32'h0000_2222, 32'h0, 5'd0);
        issue(3'd1, 2'd1, 2'd0, 32'h11, 32'h0, 32'h0, 5'd8);
        chk("lw_11_zero", bus.ResultW, 32'h0);
        issue(3'd1, 2'd1, 2'd0, 32'h20, 32'h0, 32'h0, 5'd8);
        chk("lw_20_after_sh", bus.ResultW, 32'hCAFE_F00D);

        // Result source selection.
        issue(3'd1, 2'd2, 2'd0, 32'h999, 32'h0, 32'h104, 5'd1);
        chk("pc4_result", bus.ResultW, 32'h104);
        chk("pc4_rd", 32'(bus.RDW), 32'h1);
        issue(3'd1, 2'd3, 2'd0, 32'h55, 32'h0, 32'h200, 5'd2);
        chk("src11_result", bus.ResultW, 32'h55);
        issue(3'd1, 2'd0, 2'd0, 32'h1234, 32'h0, 32'h200, 5'd3);

        // Address aliasing: 0x1010 maps onto word 4.
        issue(3'd1, 2'd1, 2'd0, 32'h1010, 32'h0, 32'h0, 5'd4);
        chk("alias_lw", bus.ResultW, 32'h8001_7FEF);
        issue(3'd0, 2'd0, 2'd1, 32'h1013, 32'h0000_005A, 32'h0, 5'd0);
        issue(3'd1, 2'd1, 2'd0, 32'h10, 32'h0, 32'h0, 5'd4);
        chk("alias_sb", bus.ResultW, 32'h5A01_7FEF);

        // Reset with a store pending in M.
        bus.RegWriteM  = 3'd0;
        bus.ResultSrcM = 2'd0;
        bus.MemWriteM  = 2'd3;
        bus.ALUResultM = 32'h10;
        bus.WriteDataM = 32'h0BAD_F00D;
        #1;
        rst     = 1'b0;
        exp_rw  = 3'd0;
        exp_rd  = 5'd0;
        exp_res = 32'h0;
        exp_mis = 1'b0;
        #1;
        chk("midrst_ResultW", bus.ResultW, 32'h0);
        chk("midrst_RDW", 32'(bus.RDW), 32'h0);
        chk("midrst_RegWriteW", 32'(bus.RegWriteW), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        issue(3'd1, 2'd1, 2'd0, 32'h10, 32'h0, 32'h0, 5'd9);
        chk("post_rst_lw", bus.ResultW, 32'h5A01_7FEF);
        chk("post_rst_rd", 32'(bus.RDW), 32'h9);
        issue(3'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
